// File: rtl/writeback_unit.sv
// writeback_unit: writeback-stage driver for the PikaRISC register file.
//
// Accepts completed results over a valid/ready handshake into a one-entry
// slot and drives the rd, pc and cpsr write ports from it. A header beat with
// in_multi=1 starts a block (load-multiple) write; each following beat writes
// the next register of the mask, lowest index first. pending_mask exposes
// every register that still has an uncommitted write for hazard detection.
//
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready                  upstream handshake
//   in_multi, in_mask                  block-write header (IDLE only)
//   in_rd_num/en/data                  rd write request; data for block beats
//   in_pc_en/data, in_cpsr_en/data     pc / cpsr write requests
//   hold, flush                        stall / discard controls
//   wb_rd_*, wb_pc_*, wb_cpsr_*        register file write ports
//   pending_mask, multi_busy           hazard / status outputs
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_multi,
  input  logic [15:0] in_mask,
  input  logic [3:0]  in_rd_num,
  input  logic        in_rd_en,
  input  logic [31:0] in_rd_data,
  input  logic        in_pc_en,
  input  logic [31:0] in_pc_data,
  input  logic        in_cpsr_en,
  input  logic [31:0] in_cpsr_data,
  input  logic        hold,
  input  logic        flush,
  output logic [3:0]  wb_rd_num,
  output logic        wb_rd_write_en,
  output logic [31:0] wb_rd_in,
  output logic        wb_pc_write_en,
  output logic [31:0] wb_pc_in,
  output logic        wb_cpsr_write_en,
  output logic [31:0] wb_cpsr_in,
  output logic [15:0] pending_mask,
  output logic        multi_busy
);

  typedef enum logic [0:0] {StIdle, StMulti} state_e;

  state_e      r_state,      w_state_d;
  logic        r_slot_valid, w_slot_valid_d;
  logic [3:0]  r_rd_num,     w_rd_num_d;
  logic        r_rd_en,      w_rd_en_d;
  logic [31:0] r_rd_data,    w_rd_data_d;
  logic        r_pc_en,      w_pc_en_d;
  logic [31:0] r_pc_data,    w_pc_data_d;
  logic        r_cpsr_en,    w_cpsr_en_d;
  logic [31:0] r_cpsr_data,  w_cpsr_data_d;
  logic [15:0] r_mask_rem,   w_mask_rem_d;

  logic        w_accept;
  logic        w_drain;
  logic [3:0]  w_low_idx;
  logic [15:0] w_mask_next;
  logic [15:0] w_slot_onehot;

  assign in_ready = !flush && (!r_slot_valid || !hold);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_slot_valid && !hold;

  // Lowest set bit of the remaining mask; scanning downward lets the lowest win.
  always_comb begin
    w_low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_mask_rem[i]) w_low_idx = 4'(i);
    end
  end

  // Clearing the lowest set bit.
  assign w_mask_next = r_mask_rem & (r_mask_rem - 16'd1);

  always_comb begin
    w_state_d      = r_state;
    w_slot_valid_d = r_slot_valid;
    w_rd_num_d     = r_rd_num;
    w_rd_en_d      = r_rd_en;
    w_rd_data_d    = r_rd_data;
    w_pc_en_d      = r_pc_en;
    w_pc_data_d    = r_pc_data;
    w_cpsr_en_d    = r_cpsr_en;
    w_cpsr_data_d  = r_cpsr_data;
    w_mask_rem_d   = r_mask_rem;

    if (flush) begin
      // Slot fields stay put so the data outputs remain stable; only validity drops.
      w_slot_valid_d = 1'b0;
      w_mask_rem_d   = 16'd0;
      w_state_d      = StIdle;
    end else begin
      if (w_drain) w_slot_valid_d = 1'b0;
      if (w_accept) begin
        case (r_state)
          StIdle: begin
            if (!in_multi) begin
              w_slot_valid_d = 1'b1;
              w_rd_num_d     = in_rd_num;
              w_rd_en_d      = in_rd_en;
              w_rd_data_d    = in_rd_data;
              w_pc_en_d      = in_pc_en;
              w_pc_data_d    = in_pc_data;
              w_cpsr_en_d    = in_cpsr_en;
              w_cpsr_data_d  = in_cpsr_data;
            end else if (in_mask != 16'd0) begin
              w_mask_rem_d = in_mask;
              w_state_d    = StMulti;
            end
          end
          StMulti: begin
            w_slot_valid_d = 1'b1;
            w_rd_num_d     = w_low_idx;
            w_rd_en_d      = 1'b1;
            w_rd_data_d    = in_rd_data;
            w_pc_en_d      = 1'b0;
            w_cpsr_en_d    = 1'b0;
            w_mask_rem_d   = w_mask_next;
            if (w_mask_next == 16'd0) w_state_d = StIdle;
          end
          default: w_state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_slot_valid <= 1'b0;
      r_rd_num     <= 4'd0;
      r_rd_en      <= 1'b0;
      r_rd_data    <= 32'd0;
      r_pc_en      <= 1'b0;
      r_pc_data    <= 32'd0;
      r_cpsr_en    <= 1'b0;
      r_cpsr_data  <= 32'd0;
      r_mask_rem   <= 16'd0;
    end else begin
      r_state      <= w_state_d;
      r_slot_valid <= w_slot_valid_d;
      r_rd_num     <= w_rd_num_d;
      r_rd_en      <= w_rd_en_d;
      r_rd_data    <= w_rd_data_d;
      r_pc_en      <= w_pc_en_d;
      r_pc_data    <= w_pc_data_d;
      r_cpsr_en    <= w_cpsr_en_d;
      r_cpsr_data  <= w_cpsr_data_d;
      r_mask_rem   <= w_mask_rem_d;
    end
  end

  assign wb_rd_num        = r_rd_num;
  assign wb_rd_in         = r_rd_data;
  assign wb_pc_in         = r_pc_data;
  assign wb_cpsr_in       = r_cpsr_data;
  assign wb_rd_write_en   = w_drain && r_rd_en;
  assign wb_pc_write_en   = w_drain && r_pc_en;
  assign wb_cpsr_write_en = w_drain && r_cpsr_en;

  assign w_slot_onehot = (r_slot_valid && r_rd_en) ? (16'd1 << r_rd_num) : 16'd0;
  assign pending_mask  = r_mask_rem | w_slot_onehot;
  assign multi_busy    = (r_state == StMulti);

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes each expected register
// file write; a negedge monitor pops and compares whenever any enable is high.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_multi;
  logic [15:0] in_mask;
  logic [3:0]  in_rd_num;
  logic        in_rd_en;
  logic [31:0] in_rd_data;
  logic        in_pc_en;
  logic [31:0] in_pc_data;
  logic        in_cpsr_en;
  logic [31:0] in_cpsr_data;
  logic        hold;
  logic        flush;
  logic [3:0]  wb_rd_num;
  logic        wb_rd_write_en;
  logic [31:0] wb_rd_in;
  logic        wb_pc_write_en;
  logic [31:0] wb_pc_in;
  logic        wb_cpsr_write_en;
  logic [31:0] wb_cpsr_in;
  logic [15:0] pending_mask;
  logic        multi_busy;

  writeback_unit dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multi         (in_multi),
    .in_mask          (in_mask),
    .in_rd_num        (in_rd_num),
    .in_rd_en         (in_rd_en),
    .in_rd_data       (in_rd_data),
    .in_pc_en         (in_pc_en),
    .in_pc_data       (in_pc_data),
    .in_cpsr_en       (in_cpsr_en),
    .in_cpsr_data     (in_cpsr_data),
    .hold             (hold),
    .flush            (flush),
    .wb_rd_num        (wb_rd_num),
    .wb_rd_write_en   (wb_rd_write_en),
    .wb_rd_in         (wb_rd_in),
    .wb_pc_write_en   (wb_pc_write_en),
    .wb_pc_in         (wb_pc_in),
    .wb_cpsr_write_en (wb_cpsr_write_en),
    .wb_cpsr_in       (wb_cpsr_in),
    .pending_mask     (pending_mask),
    .multi_busy       (multi_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd_en;
    logic [3:0]  rd_num;
    logic [31:0] rd_data;
    logic        pc_en;
    logic [31:0] pc_data;
    logic        cpsr_en;
    logic [31:0] cpsr_data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a write enable must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && (wb_rd_write_en || wb_pc_write_en || wb_cpsr_write_en)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {29'd0, wb_rd_write_en, wb_pc_write_en, wb_cpsr_write_en}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rd_en", {31'd0, wb_rd_write_en}, {31'd0, e.rd_en});
        chk("wr_pc_en", {31'd0, wb_pc_write_en}, {31'd0, e.pc_en});
        chk("wr_cpsr_en", {31'd0, wb_cpsr_write_en}, {31'd0, e.cpsr_en});
        if (e.rd_en) begin
          chk("wr_rd_num", {28'd0, wb_rd_num}, {28'd0, e.rd_num});
          chk("wr_rd_data", wb_rd_in, e.rd_data);
        end
        if (e.pc_en) chk("wr_pc_data", wb_pc_in, e.pc_data);
        if (e.cpsr_en) chk("wr_cpsr_data", wb_cpsr_in, e.cpsr_data);
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; in_multi = 0; in_mask = '0; in_rd_num = '0; in_rd_en = 0;
    in_rd_data = '0; in_pc_en = 0; in_pc_data = '0; in_cpsr_en = 0; in_cpsr_data = '0;
  endtask

  // Present a single beat for one edge.
  task automatic single(input logic [3:0] rn, input logic re, input logic [31:0] rdat,
                        input logic pe, input logic [31:0] pdat,
                        input logic ce, input logic [31:0] cdat);
    in_valid = 1; in_multi = 0; in_rd_num = rn; in_rd_en = re; in_rd_data = rdat;
    in_pc_en = pe; in_pc_data = pdat; in_cpsr_en = ce; in_cpsr_data = cdat;
    exp_q.push_back({re, rn, rdat, pe, pdat, ce, cdat});
  endtask

  task automatic header(input logic [15:0] m);
    in_valid = 1; in_multi = 1; in_mask = m;
  endtask

  // Block data beat; junk in ignored fields must not leak into the write.
  task automatic data_beat(input logic [3:0] exp_rn, input logic [31:0] d);
    in_valid = 1; in_multi = 1; in_mask = 16'hFFFF; in_rd_num = 4'd9; in_rd_en = 0;
    in_rd_data = d; in_pc_en = 1; in_pc_data = 32'h1234; in_cpsr_en = 1;
    exp_q.push_back({1'b1, exp_rn, d, 1'b0, 32'd0, 1'b0, 32'd0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; hold = 0; flush = 0;
    idle_inputs();
    step();
    step();
    @(negedge clk);
    chk("rst_outputs", {wb_rd_num, wb_rd_write_en, wb_pc_write_en, wb_cpsr_write_en},
        32'd0);
    chk("rst_rd_in", wb_rd_in, 32'd0);
    chk("rst_pc_in", wb_pc_in, 32'd0);
    chk("rst_cpsr_in", wb_cpsr_in, 32'd0);
    chk("rst_pending", {16'd0, pending_mask}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, multi_busy}, 32'd0);
    step();
    reset = 1;

    // Single beat with rd and pc.
    single(4'd3, 1, 32'hDEADBEEF, 1, 32'h40, 0, 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("single_pending", {16'd0, pending_mask}, 32'h0008);
    step();
    @(negedge clk);
    chk("single_after_pending", {16'd0, pending_mask}, 32'h0);

    // All three writes from one beat.
    step();
    single(4'd7, 1, 32'h11111111, 1, 32'h80, 1, 32'h600000D3);
    step();
    idle_inputs();

    // Block write mask 0x8012: r1, r4, r15.
    header(16'h8012);
    step();
    @(negedge clk);
    chk("blk_hdr_pending", {16'd0, pending_mask}, 32'h8012);
    chk("blk_hdr_busy", {31'd0, multi_busy}, 32'd1);
    data_beat(4'd1, 32'hAAAA0001);
    step();
    @(negedge clk);
    chk("blk_b1_pending", {16'd0, pending_mask}, 32'h8012);
    data_beat(4'd4, 32'hBBBB0004);
    step();
    @(negedge clk);
    chk("blk_b2_pending", {16'd0, pending_mask}, 32'h8010);
    chk("blk_b2_busy", {31'd0, multi_busy}, 32'd1);
    data_beat(4'd15, 32'hCCCC000F);
    step();
    idle_inputs();
    @(negedge clk);
    chk("blk_b3_pending", {16'd0, pending_mask}, 32'h8000);
    chk("blk_b3_busy", {31'd0, multi_busy}, 32'd0);
    step();

    // Hold for 3 cycles with a second beat waiting.
    single(4'd5, 1, 32'h55555555, 0, 32'd0, 0, 32'd0);
    step();
    hold = 1;
    single(4'd6, 1, 32'h66666666, 0, 32'd0, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_rd_en", {31'd0, wb_rd_write_en}, 32'd0);
      chk("hold_pending", {16'd0, pending_mask}, 32'h0020);
      step();
    end
    hold = 0;
    @(negedge clk);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    step();
    idle_inputs();
    step();
    step();

    // Flush mid-block: mask 0x00F0, one data beat, then flush.
    header(16'h00F0);
    step();
    data_beat(4'd4, 32'hD0D0D0D4);
    step();
    flush = 1;
    in_rd_data = 32'hEEEEEEEE;
    @(negedge clk);
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 0;
    idle_inputs();
    @(negedge clk);
    chk("flush_pending", {16'd0, pending_mask}, 32'h0);
    chk("flush_busy", {31'd0, multi_busy}, 32'd0);
    single(4'd2, 1, 32'hF0F0F0F2, 0, 32'd0, 0, 32'd0);
    step();
    idle_inputs();
    step();

    // Empty-mask header is a no-op.
    header(16'h0000);
    step();
    idle_inputs();
    @(negedge clk);
    chk("zmask_busy", {31'd0, multi_busy}, 32'd0);
    chk("zmask_pending", {16'd0, pending_mask}, 32'h0);
    single(4'd9, 1, 32'h99999999, 0, 32'd0, 0, 32'd0);
    step();
    idle_inputs();
    step();
    step();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
